// File: rtl/vc_mem_arb_2to1.sv
// vc_mem_arb_2to1: round-robin 2:1 memory request arbiter with in-order response steering
//   clk, reset                      : clock, synchronous active-high reset
//   req0_*/req1_*  (val/rdy/msg)    : requester request streams in
//   resp0_*/resp1_* (val/rdy/msg)   : requester response streams out
//   memreq_*  (val/rdy/msg)         : merged request stream to memory
//   memresp_* (val/rdy/msg)         : in-order response stream from memory
module vc_mem_arb_2to1 #(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4,
    localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + 2 + p_data_nbits,
    localparam int c_resp_nbits = 3 + p_opaque_nbits + 2 + 2 + p_data_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [c_req_nbits-1:0]  req0_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [c_req_nbits-1:0]  req1_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [c_resp_nbits-1:0] resp0_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [c_resp_nbits-1:0] resp1_msg,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [c_req_nbits-1:0]  memreq_msg,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [c_resp_nbits-1:0] memresp_msg
);
    localparam int c_pw = $clog2(p_max_outstanding);

    logic                         prio;
    logic [p_max_outstanding-1:0] ids;
    logic [c_pw-1:0]              wr_ptr, rd_ptr;
    logic [c_pw:0]                count;
    logic                         full, empty, grant, head, push, pop;

    // full/empty come from registered count only, so a pop never frees a slot in the same cycle
    assign full  = count == (c_pw + 1)'(p_max_outstanding);
    assign empty = count == '0;

    // grant depends only on val and prio, never on any rdy
    assign grant = (req0_val & req1_val) ? prio : req1_val;
    assign head  = ids[rd_ptr];

    assign memreq_val = !reset & (req0_val | req1_val) & !full;
    assign memreq_msg = grant ? req1_msg : req0_msg;
    assign req0_rdy   = !reset & !grant & memreq_rdy & !full;
    assign req1_rdy   = !reset &  grant & memreq_rdy & !full;

    // only the head ID may take the response, so the other port can never overtake it
    assign resp0_val   = !reset & memresp_val & !empty & !head;
    assign resp1_val   = !reset & memresp_val & !empty &  head;
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign memresp_rdy = !reset & !empty & (head ? resp1_rdy : resp0_rdy);

    assign push = memreq_val & memreq_rdy;
    assign pop  = memresp_val & memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= grant;
                wr_ptr      <= wr_ptr + 1'b1;
                prio        <= ~grant;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{c_pw{1'b0}}, push} - {{c_pw{1'b0}}, pop};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (!reset && memresp_val && empty)
            $display("ERROR: vc_mem_arb_2to1 unexpected response");

    task trace_module;
        $write("%h|%h () %h|%h",
               (req0_val && req0_rdy) ? req0_msg : '0,
               (req1_val && req1_rdy) ? req1_msg : '0,
               (resp0_val && resp0_rdy) ? resp0_msg : '0,
               (resp1_val && resp1_rdy) ? resp1_msg : '0);
    endtask
`endif
endmodule

// File: tb/tb_vc_mem_arb_2to1.sv
// tb_vc_mem_arb_2to1: directed and random scoreboard bench for the 2:1 memory arbiter
module tb_vc_mem_arb_2to1;
    localparam int RQ = 77;
    localparam int RS = 47;

    logic clk = 1'b0;
    logic reset;
    logic req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RQ-1:0] req0_msg, req1_msg, memreq_msg;
    logic resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [RS-1:0] resp0_msg, resp1_msg, memresp_msg;
    logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;

    always #5 clk = ~clk;

    vc_mem_arb_2to1 dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
    );

    int checks = 0;
    int errors = 0;
    logic [RQ-1:0] r0_q[$], r1_q[$];
    logic [RS-1:0] mem_q[$];
    logic id_q[$], glog[$], dlog[$];
    logic [7:0] olog[$];
    logic [31:0] mem_arr [logic [31:0]];
    logic m_prio = 1'b0;
    int m_count = 0;
    bit mem_en, spur, v0_en, v1_en;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RQ-1:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] d);
        return {t, op, a, 2'b00, d};
    endfunction

    // in-order memory model: applies writes at request time, returns the response message
    function automatic logic [RS-1:0] mem_op(input logic [RQ-1:0] m);
        logic [2:0]  t;
        logic [31:0] a, rd;
        t  = m[76:74];
        a  = m[65:34];
        if (t == 3'd1) mem_arr[a] = m[31:0];
        rd = (t == 3'd0 && mem_arr.exists(a)) ? mem_arr[a] : 32'h0;
        return {t, m[73:66], 2'b00, m[33:32], rd};
    endfunction

    task automatic tick();
        logic g, full, push, pop, head, ne;
        logic [RQ-1:0] m;
        req0_val    = v0_en && r0_q.size() > 0;
        req0_msg    = r0_q.size() > 0 ? r0_q[0] : '0;
        req1_val    = v1_en && r1_q.size() > 0;
        req1_msg    = r1_q.size() > 0 ? r1_q[0] : '0;
        memresp_val = spur || (mem_en && mem_q.size() > 0);
        memresp_msg = mem_q.size() > 0 ? mem_q[0] : 47'h5a5a;
        #1;
        if (reset) begin
            chk("reset_outs", {req0_rdy, req1_rdy, resp0_val, resp1_val, memreq_val, memresp_rdy}, 6'b0);
        end else begin
            g    = (req0_val && req1_val) ? m_prio : req1_val;
            full = m_count == 4;
            push = (req0_val || req1_val) && !full && memreq_rdy;
            chk("memreq_val", memreq_val, (req0_val || req1_val) && !full);
            chk("req_rdy", {req1_rdy, req0_rdy}, {g && memreq_rdy && !full, !g && memreq_rdy && !full});
            if (req0_val || req1_val) chk("memreq_msg", memreq_msg, g ? r1_q[0] : r0_q[0]);
            head = id_q.size() > 0 ? id_q[0] : 1'b0;
            ne   = m_count > 0;
            pop  = memresp_val && ne && (head ? resp1_rdy : resp0_rdy);
            chk("resp_val", {resp1_val, resp0_val}, {memresp_val && ne && head, memresp_val && ne && !head});
            chk("memresp_rdy", memresp_rdy, ne && (head ? resp1_rdy : resp0_rdy));
            if (pop) begin
                chk("resp_msg", head ? resp1_msg : resp0_msg, mem_q[0]);
                dlog.push_back(head);
                olog.push_back(mem_q[0][43:36]);
                void'(id_q.pop_front());
                void'(mem_q.pop_front());
            end
            if (push) begin
                if (g) m = r1_q.pop_front();
                else   m = r0_q.pop_front();
                id_q.push_back(g);
                glog.push_back(g);
                mem_q.push_back(mem_op(m));
                m_prio = !g;
            end
            m_count = m_count + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            id_q.delete();
            mem_q.delete();
            m_count = 0;
            m_prio  = 1'b0;
        end
        chk("count", dut.count, m_count);
        chk("prio", dut.prio, m_prio);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((r0_q.size() > 0 || r1_q.size() > 0 || m_count > 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < bound, 1'b1);
    endtask

    task automatic single_run();
        int ones = 0;
        dlog.delete();
        for (int i = 0; i < 4; i++) r0_q.push_back(mk_req(3'd0, 8'(i), 32'(i * 4), 32'h0));
        drain(40);
        foreach (dlog[k]) if (dlog[k]) ones++;
        chk("single_nresp", dlog.size(), 4);
        chk("single_resp1", ones, 0);
    endtask

    initial begin
        int wp, rp, c0;
        logic [7:0] exp_op [4];
        logic       exp_port [4];
        reset = 1'b1; memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mem_en = 1'b1; spur = 1'b0; v0_en = 1'b1; v1_en = 1'b1;
        r0_q.push_back(mk_req(3'd0, 8'h01, 32'h0, 32'h0));
        r1_q.push_back(mk_req(3'd0, 8'h02, 32'h0, 32'h0));
        tick();
        tick();
        reset = 1'b0;
        r0_q.delete();
        r1_q.delete();

        // both requesters valid every cycle: grants alternate starting at 0
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            r0_q.push_back(mk_req(3'd0, 8'(8'h40 + i), 32'(i * 4), 32'h0));
            r1_q.push_back(mk_req(3'd0, 8'(8'h80 + i), 32'(i * 4), 32'h0));
        end
        drain(40);
        chk("alt_n", glog.size(), 8);
        foreach (glog[k]) chk("alt_grant", glog[k], k % 2);

        single_run();

        // fill to depth with responses stalled; a pop does not free a slot the same cycle
        mem_en = 1'b0;
        for (int i = 0; i < 5; i++) r0_q.push_back(mk_req(3'd1, 8'(i), 32'(i * 4), 32'(100 + i)));
        repeat (5) tick();
        chk("fill_pending", r0_q.size(), 1);
        mem_en = 1'b1;
        tick();
        chk("fill_pop_nopush", r0_q.size(), 1);
        mem_en = 1'b0;
        tick();
        chk("fill_push_next", r0_q.size(), 0);
        mem_en = 1'b1;
        drain(40);

        // interleaved grants 0,1,1,0 with tagged opaques; resp1 backpressure holds the head
        mem_en = 1'b0;
        r0_q.push_back(mk_req(3'd0, 8'h10, 32'h0, 32'h0));
        tick();
        r1_q.push_back(mk_req(3'd0, 8'h21, 32'h4, 32'h0));
        r1_q.push_back(mk_req(3'd0, 8'h22, 32'h8, 32'h0));
        tick();
        tick();
        r0_q.push_back(mk_req(3'd0, 8'h13, 32'hc, 32'h0));
        tick();
        dlog.delete();
        olog.delete();
        resp1_rdy = 1'b0;
        mem_en = 1'b1;
        repeat (3) tick();
        chk("bp_stall", dlog.size(), 1);
        resp1_rdy = 1'b1;
        drain(40);
        exp_op = '{8'h10, 8'h21, 8'h22, 8'h13};
        exp_port = '{1'b0, 1'b1, 1'b1, 1'b0};
        chk("il_n", dlog.size(), 4);
        for (int k = 0; k < 4 && k < dlog.size(); k++) begin
            chk("il_port", dlog[k], exp_port[k]);
            chk("il_opaque", olog[k], exp_op[k]);
        end

        // simultaneous push and pop at count 2
        mem_en = 1'b0;
        r0_q.push_back(mk_req(3'd0, 8'h30, 32'h0, 32'h0));
        r0_q.push_back(mk_req(3'd0, 8'h31, 32'h4, 32'h0));
        tick();
        tick();
        wp = int'(dut.wr_ptr);
        rp = int'(dut.rd_ptr);
        mem_en = 1'b1;
        r0_q.push_back(mk_req(3'd0, 8'h32, 32'h8, 32'h0));
        tick();
        chk("pp_count", dut.count, 2);
        chk("pp_wr_ptr", dut.wr_ptr, (wp + 1) % 4);
        chk("pp_rd_ptr", dut.rd_ptr, (rp + 1) % 4);
        drain(40);

        // response with empty FIFO is refused
        spur = 1'b1;
        tick();
        spur = 1'b0;

        // reset with three requests in flight
        mem_en = 1'b0;
        for (int i = 0; i < 3; i++) r0_q.push_back(mk_req(3'd0, 8'(8'h50 + i), 32'(i * 4), 32'h0));
        repeat (3) tick();
        chk("mid_count3", dut.count, 3);
        r0_q.push_back(mk_req(3'd0, 8'h60, 32'h0, 32'h0));
        r1_q.push_back(mk_req(3'd0, 8'h61, 32'h0, 32'h0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r0_q.delete();
        r1_q.delete();
        mem_en = 1'b1;
        single_run();

        // random traffic with random valid, memory delay and backpressure
        dlog.delete();
        for (int i = 0; i < 100; i++) begin
            r0_q.push_back(mk_req(3'($urandom_range(0, 1)), 8'(i), 32'($urandom_range(0, 15)) << 2, $urandom));
            r1_q.push_back(mk_req(3'($urandom_range(0, 1)), 8'(8'h80 | i), 32'($urandom_range(0, 15)) << 2, $urandom));
        end
        begin
            int n = 0;
            while ((r0_q.size() > 0 || r1_q.size() > 0 || m_count > 0) && n < 4000) begin
                v0_en      = $urandom_range(0, 3) != 0;
                v1_en      = $urandom_range(0, 3) != 0;
                memreq_rdy = $urandom_range(0, 3) != 0;
                mem_en     = $urandom_range(0, 2) != 0;
                resp0_rdy  = $urandom_range(0, 3) != 0;
                resp1_rdy  = $urandom_range(0, 3) != 0;
                tick();
                n++;
            end
            chk("rand_timeout", n < 4000, 1'b1);
        end
        c0 = 0;
        foreach (dlog[k]) if (!dlog[k]) c0++;
        chk("rand_n0", c0, 100);
        chk("rand_n1", dlog.size() - c0, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vc_mem_arb_2to1.md
# vc_mem_arb_2to1

Two-requester to one-port memory arbiter. It merges two memory request streams onto a single request/response port of the dual-ported test memory (or its random-delay wrapper) and steers each in-order response back to the requester that issued it. Arbitration is round-robin. An internal ID FIFO records the grant order, so the memory message opaque field passes through unmodified.

## Interface
- p_opaque_nbits, 8: opaque field width (o)
- p_addr_nbits, 32: address width (a)
- p_data_nbits, 32: data width (d)
- p_max_outstanding, 4: ID FIFO depth, i.e. max in-flight requests; power of two, ≥2
- c_req_nbits / c_resp_nbits: `VC_MEM_REQ_MSG_NBITS(o,a,d)` / `VC_MEM_RESP_MSG_NBITS(o,d)`; local, not set externally

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req0_val / req0_rdy / req0_msg  in/out/in  1/1/c_req_nbits  requester 0 request
- req1_val / req1_rdy / req1_msg  in/out/in  1/1/c_req_nbits  requester 1 request
- resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/c_resp_nbits  requester 0 response
- resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/c_resp_nbits  requester 1 response
- memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/c_req_nbits  to memory port
- memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/c_resp_nbits  from memory port

## Operation
- State:
  - prio: 1-bit round-robin pointer.
  - ID FIFO: p_max_outstanding entries × 1 bit, plus wr_ptr, rd_ptr and count. count has width clog2(depth)+1.
  - full = (count == depth); empty = (count == 0). Both are decoded from registered count only, with no bypass.
- Grant (combinational, from val and prio only, never from any rdy):
  - Only one req valid: grant that requester.
  - Both valid: grant = prio.
  - Neither valid: no grant.
- Request path:
  - memreq_val = (req0_val | req1_val) & !full.
  - memreq_msg = msg of the granted requester, bit-exact.
  - reqN_rdy = (grant == N) & memreq_rdy & !full.
  - The ungranted requester's rdy = 0.
- Request fire (memreq_val & memreq_rdy):
  - Push grant ID into the FIFO at wr_ptr; wr_ptr increments and wraps mod depth.
  - prio <= ~grant.
  - With no fire, prio holds.
- Response path:
  - head = FIFO[rd_ptr].
  - respN_val = memresp_val & !empty & (head == N).
  - resp0_msg = resp1_msg = memresp_msg, bit-exact.
  - memresp_rdy = !empty & resp{head}_rdy.
- Response fire (memresp_val & memresp_rdy): pop; rd_ptr increments and wraps mod depth.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: −1.
- Protocol error: memresp_val while empty.
  - Response is not accepted (memresp_rdy = 0).
  - Simulation-only $display "ERROR: vc_mem_arb_2to1 unexpected response".
  - State is unchanged.
- The downstream memory port returns responses in request order; the arbiter relies on this.
- Line tracing: provide a `trace_module` task that prints req0|req1 ()
  resp0|resp1 using the codebase's mem msg trace components.

## Timing
- Reset values (while reset = 1 and on the cycle after):
  - count = 0, rd_ptr = 0, wr_ptr = 0, prio = 0.
  - All val/rdy outputs forced to 0 while reset is high.
- Latency:
  - Request path is 0-cycle combinational pass-through.
  - Response path is 0-cycle combinational pass-through.
  - A response is routable no earlier than the cycle after its request fired, because the FIFO has no bypass.
- Full:
  - memreq_val = 0 and both reqN_rdy = 0 until a pop.
  - A pop in a full cycle does not enable a push in that same cycle. Throughput at full is therefore reduced; this is required behaviour.
- Backpressure:
  - If resp{head}_rdy = 0, memresp_rdy = 0 and the FIFO holds.
  - The other requester's response can never overtake the head.
- Reset mid-operation: all in-flight IDs are discarded. The environment resets the memory simultaneously.
- Throughput: one request and one response per cycle when not full and not backpressured.

## Test plan
- Single requester: req0 issues 4 reads (addrs 0x0, 0x4, 0x8, 0xc) with mem rdy always 1.
  - memreq_msg equals req0_msg each cycle.
  - 4 responses appear only on resp0; resp1_val is never 1.
- Both valid every cycle, mem rdy = 1:
  - Grants alternate 0,1,0,1…, starting with 0 after reset.
  - After prio = 1, a cycle with only req0 valid grants 0 and sets prio = 0.
- Fill to depth 4 with memory responses stalled:
  - The 5th request sees memreq_val = 0 and req rdy = 0.
  - Releasing one response pops in cycle t; the next push fires at t+1, not t.
- Interleaved responses: grants issued in order 0,1,1,0 with tagged opaques 0x10, 0x21, 0x22, 0x13.
  - Responses are delivered on ports 0,1,1,0 with opaque unchanged.
  - Holding resp1_rdy = 0 stalls memresp_rdy until it is released.
- Same-cycle push and pop at count = 2: count stays 2 and ptrs advance by 1 each.
  - Spurious memresp_val with empty FIFO: memresp_rdy = 0 and the error is printed.
- Mid-stream reset with count = 3:
  - Next cycle count = 0 and prio = 0.
  - All val/rdy outputs are 0 while reset is high.
  - A fresh run of the single-requester scenario then passes.
- Integration: instantiate with the random-delay 2-port test memory (max_delay 4), two arbiters feeding ports 0/1, and 100 random reads/writes per requester.
  - All responses match a scoreboard.
